// File: rtl/chunked_adder.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice per clock, carry rippled between cycles,
// with valid/ready handshakes on operand input and result output.
module chunked_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);
    localparam int unsigned N = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_adder: CHUNK must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xa_q, xa_d;
    logic [WIDTH-1:0] yb_q, yb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CHUNK:0]   slice_sum;

    // One slice of the ripple chain; the carry between slices lives in carry_q.
    always_comb begin
        slice_sum = {1'b0, xa_q[idx_q*CHUNK +: CHUNK]}
                  + {1'b0, yb_q[idx_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        xa_d    = xa_q;
        yb_d    = yb_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction as x + ~y + ~c_in, so carry-out 1 means no borrow.
                    xa_d    = x;
                    yb_d    = sub ? ~y : y;
                    carry_d = sub ^ c_in;
                    s_d     = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                s_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d = slice_sum[CHUNK];
                if (idx_q == LastIdx) begin
                    c_out_d = slice_sum[CHUNK];
                    ovf_d   = (xa_q[WIDTH-1] == yb_q[WIDTH-1]) &&
                              (slice_sum[CHUNK-1] != xa_q[WIDTH-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            xa_q    <= '0;
            yb_q    <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            yb_q    <= yb_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule
